// File: rtl/alu_mul_seq.sv
// Shift-and-add multiplier sequencer that drives the shared registered adder.
// Define MUL_SIGNED_EN for two's-complement operands (sign-magnitude handling).
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_cin,
  input  logic [WIDTH:0]       add_sum
);

  // state | meaning
  // IDLE  | waiting for start; product held
  // ISSUE | operands presented to the adder
  // ACCUM | adder result captured, {ACC,Q} shifted right
  // DONE  | final {ACC,Q} moved to product; done pulses in the next cycle
  typedef enum logic [1:0] {IDLE, ISSUE, ACCUM, DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     m_reg, acc, q_reg;
  logic [CW-1:0]        cnt;
  logic                 accept;
  logic [WIDTH-1:0]     load_a, load_b;
  logic [2*WIDTH-1:0]   final_val;

  // The done cycle still counts as busy, so a start there is dropped.
  assign accept  = (state == IDLE) && start && !done;
  assign busy    = (state != IDLE) || done;
  assign add_cin = 1'b0;

`ifdef MUL_SIGNED_EN
  logic neg;
  assign load_a    = op_a[WIDTH-1] ? -op_a : op_a;
  assign load_b    = op_b[WIDTH-1] ? -op_b : op_b;
  assign final_val = neg ? -{acc, q_reg} : {acc, q_reg};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        neg <= 1'b0;
    else if (accept) neg <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
  end
`else
  assign load_a    = op_a;
  assign load_b    = op_b;
  assign final_val = {acc, q_reg};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    add_a     = '0;
    add_b     = '0;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = ACCUM;
      ACCUM:   state_nxt = (cnt == CNT_LAST) ? DONE : ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (state == ISSUE || state == ACCUM) begin
      add_a = acc;
      add_b = q_reg[0] ? m_reg : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_reg   <= '0;
      acc     <= '0;
      q_reg   <= '0;
      cnt     <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: begin
          if (accept) begin
            m_reg <= load_a;
            q_reg <= load_b;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        ACCUM: begin
          // Carry-out lands in the ACC MSB; adder LSB shifts into Q.
          acc   <= add_sum[WIDTH:1];
          q_reg <= {add_sum[0], q_reg[WIDTH-1:1]};
          if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
        end
        DONE:    product <= final_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq with a model of the shared registered adder.
// Expected products follow MUL_SIGNED_EN when it is defined.
module tb_alu_mul_seq;

  logic        clk, rst, start;
  logic [7:0]  op_a, op_b;
  logic        busy, done;
  logic [15:0] product;
  logic [7:0]  add_a, add_b;
  logic        add_cin;
  logic [8:0]  add_sum;

  int total = 0;
  int bad   = 0;

  alu_mul_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .product(product),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum)
  );

  // Shared adder: one-cycle registered sum, same reset as the sequencer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) add_sum <= '0;
    else      add_sum <= {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp_u;
    logic [15:0] exp_s;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] pick(input vec_t v);
`ifdef MUL_SIGNED_EN
    return v.exp_s;
`else
    return v.exp_u;
`endif
  endfunction

  function automatic logic [7:0] mag(input logic [7:0] x);
`ifdef MUL_SIGNED_EN
    logic [7:0] t;
    t = -x;
    return x[7] ? t : x;
`else
    return x;
`endif
  endfunction

  // Issues one multiply and watches it until busy drops (bounded).
  // g1/g2/g3: cycles after accept at which a stray start is driven.
  task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                         input int g1, input int g2, input int g3,
                         output logic [15:0] prod, output int lat,
                         output int busy_cyc, output int done_cyc,
                         output logic [7:0] addb_first, output logic [7:0] adda_first);
    op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    busy_cyc   = busy ? 1 : 0;
    addb_first = add_b;
    adda_first = add_a;
    lat = -1; done_cyc = 0; prod = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (busy) busy_cyc++;
      if (done) begin
        done_cyc++;
        if (lat < 0) begin
          lat  = n;
          prod = product;
        end
      end
      if (!busy) break;
      if (n == g1 || n == g2 || n == g3) begin
        start = 1'b1; op_a = 8'hFF; op_b = 8'hFF;
      end else begin
        start = 1'b0; op_a = a; op_b = b;
      end
    end
    start = 1'b0;
  endtask

  logic [15:0] prod;
  int          lat, bcyc, dcyc;
  logic [7:0]  addb0, adda0;

  initial begin
    vecs[0] = '{8'd13,  8'd11,  16'h008F, 16'h008F};
    vecs[1] = '{8'hFF,  8'hFF,  16'hFE01, 16'h0001};
    vecs[2] = '{8'h00,  8'hA5,  16'h0000, 16'h0000};
    vecs[3] = '{8'hFB,  8'h08,  16'h07D8, 16'hFFD8};
    vecs[4] = '{8'h80,  8'hFF,  16'h7F80, 16'h0080};
    vecs[5] = '{8'h80,  8'h7F,  16'h3F80, 16'hC080};
    vecs[6] = '{8'hA5,  8'h3C,  16'h26AC, 16'hEAAC};
    vecs[7] = '{8'h01,  8'h01,  16'h0001, 16'h0001};
    vecs[8] = '{8'hFF,  8'h01,  16'h00FF, 16'hFFFF};

    rst = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
    #12;
    chk("rst_busy",    {31'b0, busy},    32'd0);
    chk("rst_done",    {31'b0, done},    32'd0);
    chk("rst_product", {16'b0, product}, 32'd0);
    chk("rst_add_a",   {24'b0, add_a},   32'd0);
    chk("rst_add_b",   {24'b0, add_b},   32'd0);
    chk("rst_add_cin", {31'b0, add_cin}, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Stray starts at cycles 3 and 9, and during the done cycle (17).
    run_mul(8'd13, 8'd11, 3, 9, 17, prod, lat, bcyc, dcyc, addb0, adda0);
    chk("ign_product", {16'b0, prod}, 32'h008F);
    chk("ign_latency", lat,  32'd17);
    chk("ign_busy",    bcyc, 32'd18);
    chk("ign_done_w",  dcyc, 32'd1);
    chk("ign_addb0",   {24'b0, addb0}, 32'd13);
    chk("ign_adda0",   {24'b0, adda0}, 32'd0);
    @(posedge clk); #1;
    chk("ign_done_start", {31'b0, busy}, 32'd0);
    chk("ign_hold",    {16'b0, product}, 32'h008F);

    // Table: each multiply starts in the cycle right after the previous busy drop.
    for (int i = 0; i < 9; i++) begin
      run_mul(vecs[i].a, vecs[i].b, -1, -1, -1, prod, lat, bcyc, dcyc, addb0, adda0);
      chk($sformatf("vec%0d_product", i), {16'b0, prod}, {16'b0, pick(vecs[i])});
      chk($sformatf("vec%0d_latency", i), lat,  32'd17);
      chk($sformatf("vec%0d_busy", i),    bcyc, 32'd18);
      chk($sformatf("vec%0d_done_w", i),  dcyc, 32'd1);
      chk($sformatf("vec%0d_addb0", i),   {24'b0, addb0},
          {24'b0, (mag(vecs[i].b) & 8'h01) != 0 ? mag(vecs[i].a) : 8'h00});
    end

    // Reset in the middle of a multiply.
    op_a = 8'hA5; op_b = 8'h3C; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("mid_busy_pre", {31'b0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_busy",    {31'b0, busy},    32'd0);
    chk("mid_done",    {31'b0, done},    32'd0);
    chk("mid_product", {16'b0, product}, 32'd0);
    chk("mid_add_a",   {24'b0, add_a},   32'd0);
    chk("mid_add_b",   {24'b0, add_b},   32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    run_mul(8'd6, 8'd7, -1, -1, -1, prod, lat, bcyc, dcyc, addb0, adda0);
    chk("post_rst_product", {16'b0, prod}, 32'h002A);
    chk("post_rst_latency", lat,  32'd17);
    chk("post_rst_done_w",  dcyc, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
